// File: rtl/sklansky_mp_add_ctrl.sv
// Multi-precision adder sequencer: reuses one 4-bit Sklansky prefix adder per nibble, LSB first.
// Optional subtract mode is enabled by defining SKL_SUB_EN.

module Sklansky (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic       g10_s, p10_s, g32_s, p32_s, g20_s, p20_s, g30_s, p30_s;
    logic [3:0] c_s;

    // Two-level Sklansky prefix tree over generate/propagate pairs
    always_comb begin
        g_s   = A & B;
        p_s   = A ^ B;
        g10_s = g_s[1] | (p_s[1] & g_s[0]);
        p10_s = p_s[1] & p_s[0];
        g32_s = g_s[3] | (p_s[3] & g_s[2]);
        p32_s = p_s[3] & p_s[2];
        g20_s = g_s[2] | (p_s[2] & g10_s);
        p20_s = p_s[2] & p10_s;
        g30_s = g32_s | (p32_s & g10_s);
        p30_s = p32_s & p10_s;
        c_s[0] = Cin;
        c_s[1] = g_s[0] | (p_s[0] & Cin);
        c_s[2] = g10_s | (p10_s & Cin);
        c_s[3] = g20_s | (p20_s & Cin);
        Cout   = g30_s | (p30_s & Cin);
        Sum    = p_s ^ c_s;
    end
endmodule

module sklansky_mp_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SKL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDXW+1:0]   nib_base_s;
    logic [3:0]        nib_a_s;
    logic [3:0]        nib_b_s;
    logic [3:0]        nib_sum_s;
    logic              nib_cout_s;
    logic              sub_s;

`ifdef SKL_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    // Select the current nibble of the captured operands
    always_comb begin
        nib_base_s = {idx_q, 2'b00};
        nib_a_s    = a_q[nib_base_s +: 4];
        nib_b_s    = b_q[nib_base_s +: 4];
    end

    Sklansky u_add4 (
        .A    (nib_a_s),
        .B    (nib_b_s),
        .Cin  (carry_q),
        .Sum  (nib_sum_s),
        .Cout (nib_cout_s)
    );

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, nibble write-back and registered status outputs
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d = a;
                    // Subtraction is a + ~b + 1, so the caller's cin is overridden
                    if (sub_s) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
                    idx_d  = '0;
                    sum_d  = '0;
                    cout_d = 1'b0;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RUN: begin
                sum_d[nib_base_s +: 4] = nib_sum_s;
                carry_d                = nib_cout_s;
                if (idx_q == LAST_IDX) begin
                    cout_d = nib_cout_s;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: idx_d = idx_q;
            default: idx_d = '0;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_sklansky_mp_add_ctrl.sv
// Self-checking bench for sklansky_mp_add_ctrl (WIDTH=16) against an integer a+b+cin model.
// Define SKL_SUB_EN on both files to exercise the subtract mode.

module tb_sklansky_mp_add_ctrl;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef SKL_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    sklansky_mp_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SKL_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + (c ? 1 : 0);
        return r[WIDTH:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, cout, sum} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, expected all zero", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ripple();
        logic [WIDTH:0] exp_v;
        exp_v = model_add(16'hFFFF, 16'h0001, 1'b0);
        start_op(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL ripple_busy[%0d]: busy=%b done=%b, expected busy=1 done=0", i, busy, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ripple_done: busy=%b done=%b, expected busy=0 done=1", busy, done);
        end
        checks++;
        if ({cout, sum} !== exp_v || {cout, sum} !== 17'h1_0000) begin
            errors++;
            $display("FAIL ripple_result: got %h, expected %h", {cout, sum}, exp_v);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ripple_pulse: done=%b one cycle after, expected 0", done);
        end
    endtask

    task automatic test_hold();
        int n;
        logic [WIDTH:0] exp_v;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(n);
        checks++;
        if (n != 4 || {cout, sum} !== 17'h0_5555) begin
            errors++;
            $display("FAIL hold_op1: latency=%0d result=%h, expected 4 and 05555", n, {cout, sum});
        end
        tick();
        exp_v = model_add(16'hFFFF, 16'hFFFF, 1'b1);
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        a = 16'h0;
        b = 16'h0;
        wait_done(n);
        checks++;
        if (n != 4 || {cout, sum} !== exp_v || exp_v !== 17'h1_FFFF) begin
            errors++;
            $display("FAIL hold_op2: latency=%0d result=%h, expected 4 and %h", n, {cout, sum}, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cout, sum} !== exp_v || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle[%0d]: result=%h done=%b busy=%b, expected %h 0 0",
                         i, {cout, sum}, done, busy, exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        start_op(16'h00FF, 16'h0001, 1'b0);
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b1;
        start = 1'b1;
        wait_done(n);
        checks++;
        if (n != 4 || {cout, sum} !== 17'h0_0100) begin
            errors++;
            $display("FAIL ignore_result: latency=%0d result=%h, expected 4 and 00100", n, {cout, sum});
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done_start: busy=%b done=%b, expected 0 0", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || {cout, sum} !== 17'h0_0100) begin
            errors++;
            $display("FAIL ignore_after: busy=%b result=%h, expected 0 00100", busy, {cout, sum});
        end
    endtask

    task automatic test_abort();
        int n;
        int d0;
        logic [WIDTH:0] exp_v;
        start_op(16'h1234, 16'h1111, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, cout, sum} !== {3'b000, 16'h0000}) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b cout=%b sum=%h, expected all zero", busy, done, cout, sum);
        end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses after abort, expected 0", done_cnt - d0);
        end
        exp_v = model_add(16'h0F0F, 16'hF0F1, 1'b1);
        start_op(16'h0F0F, 16'hF0F1, 1'b1);
        wait_done(n);
        checks++;
        if (n != 4 || {cout, sum} !== exp_v) begin
            errors++;
            $display("FAIL abort_fresh: latency=%0d result=%h, expected 4 and %h", n, {cout, sum}, exp_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int prev_cyc;
        int d0;
        logic [WIDTH-1:0] x, y;
        logic c;
        logic [WIDTH:0] exp_v;
        prev_cyc = -1;
        d0 = done_cnt;
        for (int k = 0; k < 1000; k++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            c = 1'($urandom_range(1, 0));
            exp_v = model_add(x, y, c);
            start_op(x, y, c);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            wait_done(n);
            checks++;
            if (n != 4 || {cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL b2b_result[%0d]: %h+%h+%b latency=%0d got %h, expected 4 and %h",
                         k, x, y, c, n, {cout, sum}, exp_v);
            end
            if (prev_cyc >= 0) begin
                checks++;
                if (cyc - prev_cyc != 6) begin
                    errors++;
                    $display("FAIL b2b_period[%0d]: period %0d, expected 6", k, cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
            tick();
        end
        tick();
        checks++;
        if (done_cnt - d0 != 1000) begin
            errors++;
            $display("FAIL b2b_count: %0d done pulses, expected 1000", done_cnt - d0);
        end
    endtask

`ifdef SKL_SUB_EN
    task automatic test_sub();
        int n;
        sub = 1'b1;
        start_op(16'h0005, 16'h0007, 1'b0);
        wait_done(n);
        checks++;
        if ({cout, sum} !== 17'h0_FFFE) begin
            errors++;
            $display("FAIL sub_borrow: got %h, expected 0fffe", {cout, sum});
        end
        tick();
        start_op(16'h0007, 16'h0005, 1'b1);
        wait_done(n);
        checks++;
        if ({cout, sum} !== 17'h1_0002) begin
            errors++;
            $display("FAIL sub_noborrow: got %h, expected 10002", {cout, sum});
        end
        tick();
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ripple();
        test_hold();
        test_ignore_start();
        test_abort();
        test_back_to_back();
`ifdef SKL_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
